// File: rtl/zynet_axil_cfg_slave.sv
// AXI4-Lite configuration/result register file between the PS and the zyNet core.
// Optional feature: define AXIL_SLVERR_EN to answer illegal accesses with SLVERR.
module zynet_axil_cfg_slave #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_OUT    = 10,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_areset,
    input  logic [ADDR_WIDTH-1:0]         s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [31:0]                   s_axi_wdata,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]         s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [31:0]                   s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic [31:0]                   cfg_layer,
    output logic [31:0]                   cfg_neuron,
    output logic                          weight_valid,
    output logic [DATA_WIDTH-1:0]         weight_data,
    output logic                          bias_valid,
    output logic [DATA_WIDTH-1:0]         bias_data,
    output logic                          soft_reset,
    input  logic [DATA_WIDTH-1:0]         net_out_data,
    input  logic                          net_out_valid,
    input  logic [NUM_OUT*DATA_WIDTH-1:0] neuron_out,
    output logic                          intr
);

    localparam int unsigned PTR_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] REG_WEIGHT  = 3'd0;
    localparam logic [2:0] REG_BIAS    = 3'd1;
    localparam logic [2:0] REG_RESULT  = 3'd2;
    localparam logic [2:0] REG_LAYER   = 3'd3;
    localparam logic [2:0] REG_NEURON  = 3'd4;
    localparam logic [2:0] REG_NOUT    = 3'd5;
    localparam logic [2:0] REG_STATUS  = 3'd6;
    localparam logic [2:0] REG_SOFTRST = 3'd7;

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;

    w_state_t w_state, w_state_nx;
    r_state_t r_state, r_state_nx;

    logic [2:0]            w_addr_q;
    logic [31:0]           w_data_q;
    logic [2:0]            r_addr_q;
    logic [DATA_WIDTH-1:0] result;
    logic [PTR_W-1:0]      ptr;
    logic [DATA_WIDTH-1:0] nout_arr [NUM_OUT];

    logic wr_weight, wr_bias, wr_layer, wr_neuron, wr_soft, wr_ptr_clr, wr_err;
    logic rd_result, rd_nout, rd_err;
    logic [31:0] rd_mux;

    // Only addr[4:2] is decoded; remaining address bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr[ADDR_WIDTH-1:5], s_axi_awaddr[1:0],
                                s_axi_araddr[ADDR_WIDTH-1:5], s_axi_araddr[1:0]};

    always_comb begin
        for (int i = 0; i < int'(NUM_OUT); i++) begin
            nout_arr[i] = neuron_out[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // FSM state registers
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_nx;
            r_state <= r_state_nx;
        end
    end

    // Write FSM next state: a write is taken only when address and data are both offered
    always_comb begin
        w_state_nx = w_state;
        case (w_state)
            W_IDLE: if (s_axi_awvalid && s_axi_wvalid) w_state_nx = W_ACK;
            W_ACK:  w_state_nx = W_RESP;
            W_RESP: if (s_axi_bready) w_state_nx = W_IDLE;
            default: w_state_nx = W_IDLE;
        endcase
    end

    // Read FSM next state
    always_comb begin
        r_state_nx = r_state;
        case (r_state)
            R_IDLE: if (s_axi_arvalid) r_state_nx = R_ACK;
            R_ACK:  r_state_nx = R_DATA;
            R_DATA: if (s_axi_rready) r_state_nx = R_IDLE;
            default: r_state_nx = R_IDLE;
        endcase
    end

    // Write decode, active during the single W_ACK cycle
    always_comb begin
        wr_weight  = 1'b0;
        wr_bias    = 1'b0;
        wr_layer   = 1'b0;
        wr_neuron  = 1'b0;
        wr_soft    = 1'b0;
        wr_ptr_clr = 1'b0;
        wr_err     = 1'b0;
        if (w_state == W_ACK) begin
            case (w_addr_q)
                REG_WEIGHT:  wr_weight = 1'b1;
                REG_BIAS:    wr_bias   = 1'b1;
                REG_LAYER:   wr_layer  = 1'b1;
                REG_NEURON:  wr_neuron = 1'b1;
                REG_SOFTRST: wr_soft   = 1'b1;
                REG_NOUT: begin
`ifdef AXIL_SLVERR_EN
                    wr_err = 1'b1;
`else
                    wr_ptr_clr = 1'b1;
`endif
                end
                REG_RESULT, REG_STATUS: begin
`ifdef AXIL_SLVERR_EN
                    wr_err = 1'b1;
`endif
                end
                default: wr_err = 1'b0;
            endcase
        end
    end

    // Read mux; side-effect flags fire only on the accept cycle
    always_comb begin
        rd_mux    = 32'd0;
        rd_result = 1'b0;
        rd_nout   = 1'b0;
        rd_err    = 1'b0;
        case (r_addr_q)
            REG_RESULT: begin
                rd_mux    = 32'(result);
                rd_result = (r_state == R_ACK);
            end
            REG_LAYER:   rd_mux = cfg_layer;
            REG_NEURON:  rd_mux = cfg_neuron;
            REG_NOUT: begin
                rd_mux  = 32'(nout_arr[ptr]);
                rd_nout = (r_state == R_ACK);
            end
            REG_STATUS:  rd_mux = {29'd0, (w_state != W_IDLE), soft_reset, intr};
            REG_SOFTRST: rd_mux = {31'd0, soft_reset};
            REG_WEIGHT, REG_BIAS: begin
`ifdef AXIL_SLVERR_EN
                rd_err = 1'b1;
`endif
            end
            default: rd_mux = 32'd0;
        endcase
    end

    // AXI handshake, response and capture registers
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rdata   <= 32'd0;
            w_addr_q      <= 3'd0;
            w_data_q      <= 32'd0;
            r_addr_q      <= 3'd0;
        end else begin
            s_axi_awready <= (w_state_nx == W_ACK);
            s_axi_wready  <= (w_state_nx == W_ACK);
            s_axi_bvalid  <= (w_state_nx == W_RESP);
            s_axi_arready <= (r_state_nx == R_ACK);
            s_axi_rvalid  <= (r_state_nx == R_DATA);
            if (w_state == W_IDLE && s_axi_awvalid && s_axi_wvalid) begin
                w_addr_q <= s_axi_awaddr[4:2];
                w_data_q <= s_axi_wdata;
            end
            if (w_state == W_ACK) begin
                s_axi_bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end
            if (r_state == R_IDLE && s_axi_arvalid) begin
                r_addr_q <= s_axi_araddr[4:2];
            end
            if (r_state == R_ACK) begin
                s_axi_rdata <= rd_err ? 32'd0 : rd_mux;
                s_axi_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Core-facing config registers, strobes and result/interrupt state
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            cfg_layer    <= 32'd0;
            cfg_neuron   <= 32'd0;
            weight_valid <= 1'b0;
            weight_data  <= '0;
            bias_valid   <= 1'b0;
            bias_data    <= '0;
            soft_reset   <= 1'b1;
            intr         <= 1'b0;
            result       <= '0;
            ptr          <= '0;
        end else begin
            weight_valid <= wr_weight;
            bias_valid   <= wr_bias;
            if (wr_weight) weight_data <= w_data_q[DATA_WIDTH-1:0];
            if (wr_bias)   bias_data   <= w_data_q[DATA_WIDTH-1:0];
            if (wr_layer)  cfg_layer   <= w_data_q;
            if (wr_neuron) cfg_neuron  <= w_data_q;
            if (wr_soft)   soft_reset  <= w_data_q[0];
            if (soft_reset) begin
                intr   <= 1'b0;
                result <= '0;
                ptr    <= '0;
            end else begin
                // A new result arriving with the clearing read keeps intr set
                if (net_out_valid) begin
                    result <= net_out_data;
                    intr   <= 1'b1;
                end else if (rd_result) begin
                    intr <= 1'b0;
                end
                if (wr_ptr_clr) begin
                    ptr <= '0;
                end else if (rd_nout) begin
                    ptr <= (ptr == PTR_W'(NUM_OUT - 1)) ? '0 : ptr + PTR_W'(1);
                end
            end
        end
    end

endmodule
